rf_wport_arbiter: RTL

- Shares the register file's single write port (wen/waddr/wdata) between NREQ independent write-back requesters, e.g. the CPU write-back stage and a debug/load master.
- Round-robin arbitration with a valid/ready handshake per requester, and one registered output stage driving the register file's write port directly.
- The registered stage is also exported as a forwarding tap, so readers can bypass a write still in flight.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/rf_wport_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, the hard-wired zero register and
// the write-request record used by write-port requesters.
package rf_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    // Modulo-n increment without a divider.
    function automatic int wrapInc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// the pointer, wrapping modulo N. Kept stateless for reuse on other ports.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic                 o_found
);
    import rf_pkg::*;

    localparam int PW = $clog2(N);

    int w_scanIdx;

    always_comb begin
        o_grant   = '0;
        o_found   = 1'b0;
        w_scanIdx = 0;
        for (int k = 0; k < N; k++) begin
            w_scanIdx = int'(i_ptr) + k;
            if (w_scanIdx >= N) begin
                w_scanIdx = w_scanIdx - N;
            end
            if (!o_found && i_req[w_scanIdx[PW-1:0]]) begin
                o_grant[w_scanIdx[PW-1:0]] = 1'b1;
                o_found                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the register file's single write port among NREQ requesters with
// round-robin priority and one registered stage that doubles as a bypass tap.
module rf_wport_arbiter #(
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
    parameter int NREQ       = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_waddr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic                       rf_wen,
    output logic [ADDR_WIDTH-1:0]      rf_waddr,
    output logic [DATA_WIDTH-1:0]      rf_wdata,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       fwd_valid
);
    import rf_pkg::*;

    localparam int IDW = $clog2(NREQ);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wreq_t;

    logic [IDW-1:0]        r_ptr;
    logic                  r_valid;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [IDW-1:0]        r_gid;

    logic [NREQ-1:0]       w_grant;
    logic                  w_found;
    logic [IDW-1:0]        w_idx;
    wreq_t                 w_sel;

    rr_arbiter #(
        .N(NREQ)
    ) u_rr (
        .i_req  (req_valid),
        .i_ptr  (r_ptr),
        .o_grant(w_grant),
        .o_found(w_found)
    );

    // One-hot grant to index plus winner's request mux.
    always_comb begin
        w_idx = '0;
        w_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_idx      = IDW'(i);
                w_sel.addr = req_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel.data = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The stage never stalls, so the winner is accepted whenever out of reset.
    assign req_ready = w_grant & {NREQ{rst}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= IDW'(wrapInc(int'(w_idx), NREQ));
        end
    end

    // x0 writes still occupy the stage (visible on the tap) but never enable the file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_gid   <= '0;
        end else if (w_found) begin
            r_valid <= 1'b1;
            r_wen   <= (w_sel.addr != ADDR_WIDTH'(ZERO_REG));
            r_waddr <= w_sel.addr;
            r_wdata <= w_sel.data;
            r_gid   <= w_idx;
        end else begin
            r_valid <= 1'b0;
            r_wen   <= 1'b0;
        end
    end

    assign rf_wen    = r_wen;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign grant_id  = r_gid;
    assign fwd_valid = r_valid;

endmodule
